// File: rtl/alu_operand_stage.sv
// 6502 ALU operand stage: A/B operand capture on posedge phi_2, combinational function
// (binary/BCD add, logic ops, shift right), carry/overflow/half-carry registered on negedge.
module alu_operand_stage (
  input  logic       phi_2,
  input  logic       reset,
  input  logic [7:0] sb_bus,
  input  logic [7:0] db_bus,
  input  logic [7:0] adl_bus,
  input  logic       zero_add,
  input  logic       sb_add,
  input  logic       db_add,
  input  logic       ndb_add,
  input  logic       adl_add,
  input  logic       carry_in,
  input  logic       sums,
  input  logic       ands,
  input  logic       eors,
  input  logic       ors,
  input  logic       srs,
  input  logic       daa,
  input  logic       dsa,
  output logic [7:0] alu_to_add,
  output logic       acr,
  output logic       avr,
  output logic       hc
);

  logic [7:0] r_a;
  logic [7:0] r_b;
  logic       r_cin;
  logic       r_sums;
  logic       r_ands;
  logic       r_eors;
  logic       r_ors;
  logic       r_srs;
  logic       r_daa;
  logic       r_dsa;

  logic [8:0] w_s9;
  logic [4:0] w_lo_bin;
  logic       w_hc_bin;
  logic       w_avr_bin;
  logic [4:0] w_dlo;
  logic [4:0] w_dhi;
  logic       w_dhc;
  logic       w_dacr;
  logic [3:0] w_slo;
  logic [3:0] w_shi;
  logic [7:0] w_result;
  logic       w_acr;
  logic       w_avr;
  logic       w_hc;

  always_ff @(posedge phi_2 or posedge reset) begin
    if (reset) begin
      r_a    <= 8'h00;
      r_b    <= 8'h00;
      r_cin  <= 1'b0;
      r_sums <= 1'b0;
      r_ands <= 1'b0;
      r_eors <= 1'b0;
      r_ors  <= 1'b0;
      r_srs  <= 1'b0;
      r_daa  <= 1'b0;
      r_dsa  <= 1'b0;
    end else begin
      if (zero_add) begin
        r_a <= 8'h00;
      end else if (sb_add) begin
        r_a <= sb_bus;
      end
      if (db_add) begin
        r_b <= db_bus;
      end else if (ndb_add) begin
        r_b <= ~db_bus;
      end else if (adl_add) begin
        r_b <= adl_bus;
      end
      r_cin  <= carry_in;
      r_sums <= sums;
      r_ands <= ands;
      r_eors <= eors;
      r_ors  <= ors;
      r_srs  <= srs;
      r_daa  <= daa;
      r_dsa  <= dsa;
    end
  end

  // Binary sum and its flags; the decimal paths reuse these.
  always_comb begin
    w_s9      = {1'b0, r_a} + {1'b0, r_b} + {8'd0, r_cin};
    w_lo_bin  = {1'b0, r_a[3:0]} + {1'b0, r_b[3:0]} + {4'd0, r_cin};
    w_hc_bin  = w_lo_bin[4];
    w_avr_bin = (r_a[7] == r_b[7]) && (w_s9[7] != r_a[7]);
  end

  // Decimal add adjust: nibble carries come from the adjusted digits.
  always_comb begin
    w_dlo = w_lo_bin;
    w_dhc = 1'b0;
    if (w_lo_bin > 5'd9) begin
      w_dlo = w_lo_bin + 5'd6;
      w_dhc = 1'b1;
    end
    w_dhi  = {1'b0, r_a[7:4]} + {1'b0, r_b[7:4]} + {4'd0, w_dhc};
    w_dacr = 1'b0;
    if (w_dhi > 5'd9) begin
      w_dhi  = w_dhi + 5'd6;
      w_dacr = 1'b1;
    end
  end

  // Decimal subtract adjust: a borrow out of a nibble means that digit needs -6.
  always_comb begin
    w_slo = w_hc_bin ? w_s9[3:0] : (w_s9[3:0] - 4'd6);
    w_shi = w_s9[8]  ? w_s9[7:4] : (w_s9[7:4] - 4'd6);
  end

  always_comb begin
    w_result = 8'h00;
    w_acr    = 1'b0;
    w_avr    = 1'b0;
    w_hc     = 1'b0;
    if (r_sums) begin
      w_avr = w_avr_bin;
      if (r_daa) begin
        w_result = {w_dhi[3:0], w_dlo[3:0]};
        w_acr    = w_dacr;
        w_hc     = w_dhc;
      end else if (r_dsa) begin
        w_result = {w_shi, w_slo};
        w_acr    = w_s9[8];
        w_hc     = w_hc_bin;
      end else begin
        w_result = w_s9[7:0];
        w_acr    = w_s9[8];
        w_hc     = w_hc_bin;
      end
    end else if (r_ands) begin
      w_result = r_a & r_b;
    end else if (r_eors) begin
      w_result = r_a ^ r_b;
    end else if (r_ors) begin
      w_result = r_a | r_b;
    end else if (r_srs) begin
      w_result = {r_cin, r_a[7:1]};
      w_acr    = r_a[0];
    end
  end

  assign alu_to_add = w_result;

  always_ff @(negedge phi_2 or posedge reset) begin
    if (reset) begin
      acr <= 1'b0;
      avr <= 1'b0;
      hc  <= 1'b0;
    end else begin
      acr <= w_acr;
      avr <= w_avr;
      hc  <= w_hc;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed, table-driven bench for alu_operand_stage with hand sequences for reset,
// flag hold and carry chaining.
module tb_alu_operand_stage;

  logic       phi_2;
  logic       reset;
  logic [7:0] sb_bus, db_bus, adl_bus;
  logic       zero_add, sb_add, db_add, ndb_add, adl_add;
  logic       carry_in, sums, ands, eors, ors, srs, daa, dsa;
  logic [7:0] alu_to_add;
  logic       acr, avr, hc;

  int checks;
  int failures;

  alu_operand_stage dut (
    .phi_2      (phi_2),
    .reset      (reset),
    .sb_bus     (sb_bus),
    .db_bus     (db_bus),
    .adl_bus    (adl_bus),
    .zero_add   (zero_add),
    .sb_add     (sb_add),
    .db_add     (db_add),
    .ndb_add    (ndb_add),
    .adl_add    (adl_add),
    .carry_in   (carry_in),
    .sums       (sums),
    .ands       (ands),
    .eors       (eors),
    .ors        (ors),
    .srs        (srs),
    .daa        (daa),
    .dsa        (dsa),
    .alu_to_add (alu_to_add),
    .acr        (acr),
    .avr        (avr),
    .hc         (hc)
  );

  initial phi_2 = 1'b0;
  always #5 phi_2 = ~phi_2;

  // ld = {zero, sb, db, ndb, adl}; fn = {sums, ands, eors, ors, srs, daa, dsa};
  // flg = {acr, avr, hc}
  typedef struct {
    string      name;
    logic [7:0] sb;
    logic [7:0] db;
    logic [7:0] adl;
    logic [4:0] ld;
    logic       cin;
    logic [6:0] fn;
    logic [7:0] res;
    logic [2:0] flg;
  } vec_t;

  vec_t vecs[18];

  function automatic vec_t mk(input string name, input logic [7:0] sb, input logic [7:0] db,
                              input logic [7:0] adl, input logic [4:0] ld, input logic cin,
                              input logic [6:0] fn, input logic [7:0] res,
                              input logic [2:0] flg);
    vec_t v;
    v.name = name; v.sb = sb; v.db = db; v.adl = adl; v.ld = ld;
    v.cin = cin; v.fn = fn; v.res = res; v.flg = flg;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    {zero_add, sb_add, db_add, ndb_add, adl_add} = v.ld;
    {sums, ands, eors, ors, srs, daa, dsa} = v.fn;
    carry_in = v.cin;
    sb_bus   = (v.ld[4] || v.ld[3]) ? v.sb : 8'hzz;
    db_bus   = v.db;
    adl_bus  = v.ld[0] ? v.adl : 8'hzz;
  endtask

  // Drive just after a negedge; result checked after posedge, flags after negedge.
  task automatic run(input vec_t v);
    drive(v);
    @(posedge phi_2);
    #1;
    check({v.name, "_res"}, alu_to_add, v.res);
    @(negedge phi_2);
    #1;
    check({v.name, "_flags"}, {5'd0, acr, avr, hc}, {5'd0, v.flg});
  endtask

  initial begin
    vec_t idle;
    checks   = 0;
    failures = 0;
    idle = mk("idle", 8'h00, 8'h00, 8'h00, 5'b00000, 1'b0, 7'b0000000, 8'h00, 3'b000);

    vecs[0]  = mk("sum_12_34",  8'h12, 8'h34, 8'h00, 5'b01100, 1'b0, 7'b1000000, 8'h46, 3'b000);
    vecs[1]  = mk("bin_7f_01",  8'h7F, 8'h01, 8'h00, 5'b01100, 1'b0, 7'b1000000, 8'h80, 3'b011);
    vecs[2]  = mk("daa_09_01",  8'h09, 8'h01, 8'h00, 5'b01100, 1'b0, 7'b1000010, 8'h10, 3'b001);
    vecs[3]  = mk("daa_99_01",  8'h99, 8'h01, 8'h00, 5'b01100, 1'b0, 7'b1000010, 8'h00, 3'b101);
    vecs[4]  = mk("dsa_10_01",  8'h10, 8'h01, 8'h00, 5'b01010, 1'b1, 7'b1000001, 8'h09, 3'b100);
    vecs[5]  = mk("dsa_00_01",  8'h00, 8'h01, 8'h00, 5'b01010, 1'b1, 7'b1000001, 8'h99, 3'b000);
    vecs[6]  = mk("zero_prio",  8'hAA, 8'h03, 8'h00, 5'b11100, 1'b0, 7'b1000000, 8'h03, 3'b000);
    vecs[7]  = mk("a_hold",     8'hFF, 8'h05, 8'h00, 5'b00100, 1'b0, 7'b1000000, 8'h05, 3'b000);
    vecs[8]  = mk("db_over_adl", 8'h00, 8'h11, 8'h22, 5'b00101, 1'b0, 7'b1000000, 8'h11, 3'b000);
    vecs[9]  = mk("ndb_over_adl", 8'h01, 8'h0F, 8'h55, 5'b01011, 1'b0, 7'b1000000, 8'hF1, 3'b000);
    vecs[10] = mk("srs_81",     8'h81, 8'h00, 8'h00, 5'b01000, 1'b1, 7'b0000100, 8'hC0, 3'b100);
    vecs[11] = mk("no_func",    8'hFF, 8'hFF, 8'h00, 5'b01100, 1'b1, 7'b0000000, 8'h00, 3'b000);
    vecs[12] = mk("and_over_or", 8'hF0, 8'h3C, 8'h00, 5'b01100, 1'b0, 7'b0101000, 8'h30, 3'b000);
    vecs[13] = mk("eor",        8'hF0, 8'h3C, 8'h00, 5'b01100, 1'b0, 7'b0010000, 8'hCC, 3'b000);
    vecs[14] = mk("or",         8'hF0, 8'h3C, 8'h00, 5'b01100, 1'b0, 7'b0001000, 8'hFC, 3'b000);
    vecs[15] = mk("bin_ff_01",  8'hFF, 8'h01, 8'h00, 5'b01100, 1'b0, 7'b1000000, 8'h00, 3'b101);
    vecs[16] = mk("daa_over_dsa", 8'h15, 8'h27, 8'h00, 5'b01100, 1'b0, 7'b1000011, 8'h42, 3'b001);
    vecs[17] = mk("srs_02",     8'h02, 8'h00, 8'h00, 5'b01000, 1'b0, 7'b0000100, 8'h01, 3'b000);

    drive(idle);
    reset = 1'b1;
    #1;
    check("reset_res", alu_to_add, 8'h00);
    check("reset_flags", {5'd0, acr, avr, hc}, 8'h00);
    @(negedge phi_2);
    @(negedge phi_2);
    #1;
    reset = 1'b0;

    // Build up nonzero state, then reset between edges and expect an immediate clear.
    run(vecs[15]);
    drive(vecs[1]);
    @(posedge phi_2);
    #1;
    check("pre_reset_res", alu_to_add, 8'h80);
    #1 reset = 1'b1;
    #1;
    check("midreset_res", alu_to_add, 8'h00);
    check("midreset_flags", {5'd0, acr, avr, hc}, 8'h00);
    #1 reset = 1'b0;
    drive(idle);
    @(negedge phi_2);
    #1;

    for (int i = 0; i < 18; i++) run(vecs[i]);

    // Flags hold until the negedge even though the function changed at posedge.
    run(vecs[15]);
    drive(mk("hold", 8'h00, 8'h00, 8'h00, 5'b00000, 1'b0, 7'b0100000, 8'h01, 3'b000));
    @(posedge phi_2);
    #1;
    check("flag_hold_res", alu_to_add, 8'h01);
    check("flag_hold_flags", {5'd0, acr, avr, hc}, 8'h05);
    @(negedge phi_2);
    #1;
    check("flag_update_flags", {5'd0, acr, avr, hc}, 8'h00);

    // Carry chaining: registered acr fed back as carry_in.
    run(vecs[15]);
    drive(mk("chain", 8'h00, 8'h00, 8'h00, 5'b01100, 1'b0, 7'b1000000, 8'h01, 3'b000));
    carry_in = acr;
    @(posedge phi_2);
    #1;
    check("carry_chain_res", alu_to_add, 8'h01);
    @(negedge phi_2);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Operand-side counterpart of the adder hold register. It captures ALU operands from the internal buses (SB, DB, ADL) into the A and B input registers on the rising edge of phi_2. It computes the selected 6502 ALU function, including BCD add and subtract adjust, and presents the 8-bit result on `alu_to_add` before the falling edge, where the adder hold register latches it. The carry, overflow and half-carry flags are registered on that same falling edge for use by the processor-status logic.

## Interface
- No parameters.
- `phi_2` in 1: system clock. Operands load on posedge; flags register on negedge.
- `reset` in 1: asynchronous, active-high. Clears all state immediately.
- `sb_bus` in 8: special bus.
- `db_bus` in 8: data bus.
- `adl_bus` in 8: address-low bus.
- `zero_add` in 1: load A with 0x00.
- `sb_add` in 1: load A from `sb_bus`.
- `db_add` in 1: load B from `db_bus`.
- `ndb_add` in 1: load B from `~db_bus`.
- `adl_add` in 1: load B from `adl_bus`.
- `carry_in` in 1: ALU carry input, sampled with the operands.
- `sums`, `ands`, `eors`, `ors`, `srs` in 1 each: function select, sampled with the operands.
- `daa` in 1: decimal add adjust, sampled with the operands.
- `dsa` in 1: decimal subtract adjust, sampled with the operands.
- `alu_to_add` out 8: ALU result, combinational from the registered operands.
- `acr` out 1: registered carry out.
- `avr` out 1: registered overflow.
- `hc` out 1: registered half carry.

## Operation
- **Operand capture (posedge phi_2)**
  - A register:
    - `zero_add` set → A = 0x00. `zero_add` has priority over `sb_add`.
    - Else `sb_add` set → A = `sb_bus`.
    - Else A holds its value.
  - B register, priority `db_add` > `ndb_add` > `adl_add`; with none asserted, B holds its value.
  - `carry_in`, function selects, `daa` and `dsa` are registered on the same edge into a control register.
- **Function select**
  - Priority: sums > ands > eors > ors > srs.
  - With no function selected, the result is 0x00 and the next flag update writes acr = avr = hc = 0.
- **SUMS (binary)**
  - S9 = A + B + cin, 9 bits.
  - result = S9[7:0]; acr = S9[8].
  - hc = carry out of bit 3, i.e. (A[3:0] + B[3:0] + cin) > 15.
  - avr = (A[7] == B[7]) && (S9[7] != A[7]).
- **SUMS with daa** (`dsa` ignored when `daa` is set)
  - Low nibble: lo = A[3:0] + B[3:0] + cin. If lo > 9: lo += 6 and hc = 1.
  - High nibble: hi = A[7:4] + B[7:4] + hc. If hi > 9: hi += 6 and acr = 1.
  - result = {hi[3:0], lo[3:0]}.
  - avr is always taken from the binary S9.
- **SUMS with dsa** (B already holds `~db`, cin = 1 for no borrow)
  - Compute the binary result first.
  - If hc = 0, subtract 6 from the low nibble, modulo 16.
  - If acr = 0, subtract 6 from the high nibble, modulo 16.
  - Flags are taken from the binary computation.
- **Logic functions**
  - ANDS, EORS, ORS: bitwise A op B.
  - acr = avr = hc = 0.
- **SRS**
  - result = {cin, A[7:1]}; acr = A[0]; avr = hc = 0.
- **Flag update (negedge phi_2)**
  - acr, avr and hc are loaded from the current combinational values.
  - This is the same edge on which the hold register captures `alu_to_add`.

## Timing
- **Reset**
  - A, B and the control register clear to 0; acr = avr = hc = 0.
  - With the control register cleared, `alu_to_add` = 0x00.
  - Reset asserted mid-cycle wins over either clock edge.
  - After reset releases, the first posedge loads normally.
- **Latency**
  - `alu_to_add` is valid one combinational delay after posedge phi_2.
  - The flags are valid after the following negedge, half a cycle later.
- **Operand and flag hold**
  - An operand with no load strobe keeps its value across cycles, so one operand can be reused in multi-cycle address arithmetic.
  - Flags hold between negedges, even when the function select changes.
- **Carry chaining**
  - `acr` registered on negedge N is stable before posedge N+1, so it can be fed back as `carry_in`.
- **Bus sampling**
  - The block never drives a bus. Tri-state (z) bus inputs that are not selected are ignored.

## Test plan
- Pulse reset mid-cycle → `alu_to_add` = 0x00, acr/avr/hc = 0 immediately; the next load with A = 0x12, B = 0x34, sums → 0x46.
- Binary: A = 0x7F, B = 0x01, cin = 0, sums → result 0x80; after negedge avr = 1, acr = 0, hc = 1.
- Decimal add:
  - 0x09 + 0x01, daa → 0x10, hc = 1, acr = 0.
  - 0x99 + 0x01, daa → 0x00, acr = 1.
- Decimal subtract:
  - A = 0x10, B = `~0x01` via `ndb_add`, cin = 1, dsa → 0x09, acr = 1.
  - A = 0x00, B = `~0x01`, cin = 1, dsa → 0x99, acr = 0.
- Priority and hold:
  - `zero_add` and `sb_add` both set with `sb_bus` = 0xAA → A = 0x00.
  - Next cycle, only `db_add` with 0x05, sums → 0x05, confirming A held.
  - `db_add` and `adl_add` both set → B comes from DB.
- SRS with A = 0x81, cin = 1 → 0xC0, acr = 1.
- Two functions selected (ands and ors) → AND result.
- No function selected → 0x00 and all flags clear.
